// File: rtl/sdram_arbiter.sv
// sdram_arbiter
//   Shares one SDRAM controller command port among three requesters:
//   port 0 = PPU CHR fetch, port 1 = CPU PRG/WRAM, port 2 = SD-card ROM loader.
//   Fixed priority (lowest index wins) with a starvation boost for ports 1 and 2.
//   Only one transaction is outstanding at a time. All outputs are registered.
//
// Ports
//   m_clock, p_reset         clock, asynchronous active-high reset
//   req/we/addr/wdata        per-port request side (port n at slice n)
//   ack, rvalid, rdata       per-port accept pulse, read-data pulse, shared read data
//   mem_req/we/addr/wdata    command to the SDRAM sequencer, held until mem_ack
//   mem_ack, mem_rvalid,
//   mem_rdata                sequencer accept, read-data strobe and data
module sdram_arbiter #(
  parameter int unsigned AW         = 22,
  parameter int unsigned DW         = 16,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic            m_clock,
  input  logic            p_reset,
  input  logic [2:0]      req,
  input  logic [2:0]      we,
  input  logic [3*AW-1:0] addr,
  input  logic [3*DW-1:0] wdata,
  output logic [2:0]      ack,
  output logic [2:0]      rvalid,
  output logic [DW-1:0]   rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic            mem_ack,
  input  logic            mem_rvalid,
  input  logic [DW-1:0]   mem_rdata
);

  localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

  typedef enum logic [1:0] {StIdle, StIssue, StWaitRd} state_e;

  state_e          state_q, state_d;
  logic [1:0]      g_q, g_d;
  logic            mem_req_q, mem_req_d;
  logic            mem_we_q, mem_we_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic [2:0]      ack_q, ack_d;
  logic [2:0]      rvalid_q, rvalid_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic [3:0]      cnt1_q, cnt1_d;
  logic [3:0]      cnt2_q, cnt2_d;

  logic [2:0]      elig;
  logic            boost1, boost2;
  logic [1:0]      win;

  // A port whose ack is on the wire this cycle is still holding req; mask it so
  // the stale request is not taken as a new one.
  assign elig   = req & ~ack_q;
  assign boost1 = elig[1] && (cnt1_q >= StarveMax);
  assign boost2 = elig[2] && (cnt2_q >= StarveMax);

  always_comb begin
    win = 2'd2;
    if (boost1)       win = 2'd1;
    else if (boost2)  win = 2'd2;
    else if (elig[0]) win = 2'd0;
    else if (elig[1]) win = 2'd1;
  end

  always_comb begin
    state_d     = state_q;
    g_d         = g_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    ack_d       = 3'b000;
    rvalid_d    = 3'b000;
    rdata_d     = rdata_q;
    cnt1_d      = cnt1_q;
    cnt2_d      = cnt2_q;

    unique case (state_q)
      StIdle: begin
        if (|elig) begin
          g_d       = win;
          mem_req_d = 1'b1;
          state_d   = StIssue;
          unique case (win)
            2'd0: begin
              mem_we_d    = we[0];
              mem_addr_d  = addr[0*AW +: AW];
              mem_wdata_d = wdata[0*DW +: DW];
            end
            2'd1: begin
              mem_we_d    = we[1];
              mem_addr_d  = addr[1*AW +: AW];
              mem_wdata_d = wdata[1*DW +: DW];
            end
            default: begin
              mem_we_d    = we[2];
              mem_addr_d  = addr[2*AW +: AW];
              mem_wdata_d = wdata[2*DW +: DW];
            end
          endcase
          // Losers that were eligible age by one; the winner starts over.
          if (elig[1]) begin
            if (win == 2'd1)         cnt1_d = 4'd0;
            else if (cnt1_q != 4'hF) cnt1_d = cnt1_q + 4'd1;
          end
          if (elig[2]) begin
            if (win == 2'd2)         cnt2_d = 4'd0;
            else if (cnt2_q != 4'hF) cnt2_d = cnt2_q + 4'd1;
          end
        end
      end
      StIssue: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          ack_d     = 3'b001 << g_q;
          state_d   = mem_we_q ? StIdle : StWaitRd;
        end
      end
      StWaitRd: begin
        if (mem_rvalid) begin
          rdata_d  = mem_rdata;
          rvalid_d = 3'b001 << g_q;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge m_clock or posedge p_reset) begin
    if (p_reset) begin
      state_q     <= StIdle;
      g_q         <= 2'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      ack_q       <= 3'b000;
      rvalid_q    <= 3'b000;
      rdata_q     <= '0;
      cnt1_q      <= 4'd0;
      cnt2_q      <= 4'd0;
    end else begin
      state_q     <= state_d;
      g_q         <= g_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      ack_q       <= ack_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      cnt1_q      <= cnt1_d;
      cnt2_q      <= cnt2_d;
    end
  end

  assign ack       = ack_q;
  assign rvalid    = rvalid_q;
  assign rdata     = rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Scoreboarded bench for sdram_arbiter: expected commands are queued in the
// predicted grant order when requests are raised, and checked as the arbiter
// presents them to the modelled SDRAM controller.
module tb_sdram_arbiter;

  localparam int AW = 22;
  localparam int DW = 16;

  logic            m_clock = 1'b0;
  logic            p_reset = 1'b1;
  logic [2:0]      req = '0;
  logic [2:0]      we = '0;
  logic [3*AW-1:0] addr = '0;
  logic [3*DW-1:0] wdata = '0;
  logic [2:0]      ack;
  logic [2:0]      rvalid;
  logic [DW-1:0]   rdata;
  logic            mem_req;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic            mem_ack = 1'b0;
  logic            mem_rvalid = 1'b0;
  logic [DW-1:0]   mem_rdata = '0;

  sdram_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(8)) dut (
    .m_clock    (m_clock),
    .p_reset    (p_reset),
    .req        (req),
    .we         (we),
    .addr       (addr),
    .wdata      (wdata),
    .ack        (ack),
    .rvalid     (rvalid),
    .rdata      (rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  always #5 m_clock = ~m_clock;

  typedef struct {
    int            port;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   last_wait = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge m_clock);
    #1;
  endtask

  task automatic push_exp(input int p, input logic w, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd, input logic [DW-1:0] rd);
    exp_t e;
    e.port = p; e.we = w; e.addr = a; e.wdata = wd; e.rdata = rd;
    sb_q.push_back(e);
  endtask

  task automatic issue(input int p, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd, input logic [DW-1:0] rd);
    we[p]              = w;
    addr[p*AW +: AW]   = a;
    wdata[p*DW +: DW]  = wd;
    req[p]             = 1'b1;
    push_exp(p, w, a, wd, rd);
  endtask

  // Controller model for one transaction: wait for the command, check it
  // against the scoreboard, accept it after ack_dly cycles, return read data.
  task automatic serve(input int ack_dly, input int rv_dly, input bit drop);
    exp_t e;
    int   waited = 0;
    while (!mem_req && waited < 50) begin
      step();
      waited++;
    end
    last_wait = waited;
    if (!mem_req) begin
      check_eq("mem_req_timeout", 32'(mem_req), 32'd1);
      return;
    end
    if (sb_q.size() == 0) begin
      check_eq("sb_underflow", 32'd0, 32'd1);
      return;
    end
    e = sb_q.pop_front();
    check_eq("cmd_we", 32'(mem_we), 32'(e.we));
    check_eq("cmd_addr", 32'(mem_addr), 32'(e.addr));
    if (e.we) check_eq("cmd_wdata", 32'(mem_wdata), 32'(e.wdata));
    repeat (ack_dly) begin
      step();
      check_eq("cmd_held", 32'(mem_req), 32'd1);
      check_eq("cmd_addr_held", 32'(mem_addr), 32'(e.addr));
    end
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    check_eq("ack", 32'(ack), 32'(3'b001 << e.port));
    check_eq("ack_mem_req", 32'(mem_req), 32'd0);
    check_eq("ack_no_rvalid", 32'(rvalid), 32'd0);
    step();
    check_eq("ack_pulse", 32'(ack), 32'd0);
    if (drop) req[e.port] = 1'b0;
    if (!e.we) begin
      repeat (rv_dly) step();
      mem_rvalid = 1'b1;
      mem_rdata  = e.rdata;
      step();
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
      check_eq("rvalid", 32'(rvalid), 32'(3'b001 << e.port));
      check_eq("rdata", 32'(rdata), 32'(e.rdata));
      step();
      check_eq("rvalid_pulse", 32'(rvalid), 32'd0);
    end else begin
      check_eq("wr_no_rvalid", 32'(rvalid), 32'd0);
    end
  endtask

  task automatic do_reset();
    req = '0;
    mem_ack = 1'b0;
    mem_rvalid = 1'b0;
    p_reset = 1'b1;
    step();
    step();
    p_reset = 1'b0;
    sb_q.delete();
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_mem_req"}, 32'(mem_req), 32'd0);
    check_eq({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    check_eq({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check_eq({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    check_eq({tag, "_ack"}, 32'(ack), 32'd0);
    check_eq({tag, "_rvalid"}, 32'(rvalid), 32'd0);
    check_eq({tag, "_rdata"}, 32'(rdata), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;

    // Reset state
    do_reset();
    check_idle_outputs("reset");

    // 1: single write from port 1, one-cycle request latency
    step();
    issue(1, 1'b1, 22'h00100, 16'hBEEF, 16'h0000);
    serve(2, 0, 1'b1);
    check_eq("t1_latency", 32'(last_wait), 32'd1);

    // 2: read from port 0 at the top address
    step();
    issue(0, 1'b0, 22'h3FFFFF, 16'h0000, 16'h1234);
    serve(1, 2, 1'b1);

    // 3a: all three at once, each drops after its ack -> order 0,1,2
    step();
    issue(0, 1'b1, 22'h000A0, 16'h1111, 16'h0000);
    issue(1, 1'b1, 22'h000B1, 16'h2222, 16'h0000);
    issue(2, 1'b1, 22'h000C2, 16'h3333, 16'h0000);
    serve(0, 0, 1'b1);
    serve(1, 0, 1'b1);
    serve(0, 0, 1'b1);

    // 3b: port 0 keeps reading; port 1 must win after 8 port-0 grants,
    // port 2 on the grant after that
    do_reset();
    step();
    issue(0, 1'b0, 22'h00040, 16'h0000, 16'h1000);
    for (int i = 1; i < 8; i++) push_exp(0, 1'b0, 22'h00040, 16'h0000, 16'(16'h1000 + i));
    issue(1, 1'b1, 22'h00051, 16'h5151, 16'h0000);
    issue(2, 1'b1, 22'h00062, 16'h6262, 16'h0000);
    for (int i = 0; i < 8; i++) serve(0, 1, 1'b0);
    serve(1, 0, 1'b1);
    req[0] = 1'b0;  // port 2 is already in ISSUE here; stop port 0 re-requesting
    serve(0, 0, 1'b1);
    step();
    step();
    check_eq("t3_idle_after", 32'(mem_req), 32'd0);

    // 4: reset during the ack cycle of a read, late rvalid ignored afterwards
    req[1]            = 1'b1;
    we[1]             = 1'b0;
    addr[1*AW +: AW]  = 22'h2AAAA;
    waited = 0;
    while (!mem_req && waited < 20) begin
      step();
      waited++;
    end
    check_eq("t4_cmd_addr", 32'(mem_addr), 32'h2AAAA);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    check_eq("t4_ack", 32'(ack), 32'b010);
    #2;
    p_reset = 1'b1;
    #1;
    check_idle_outputs("t4_async");
    req[1] = 1'b0;
    step();
    p_reset = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 16'hCAFE;
    step();
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    check_eq("t4_late_rvalid", 32'(rvalid), 32'd0);
    check_eq("t4_late_rdata", 32'(rdata), 32'd0);
    check_eq("t4_late_mem_req", 32'(mem_req), 32'd0);

    // 5: stray mem_ack in IDLE, stray mem_rvalid in ISSUE
    sb_q.delete();
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    check_eq("t5_stray_ack", 32'(ack), 32'd0);
    check_eq("t5_stray_ack_req", 32'(mem_req), 32'd0);
    step();
    check_eq("t5_idle_hold", 32'(mem_req), 32'd0);
    issue(2, 1'b0, 22'h155555, 16'h0000, 16'hA5A5);
    step();
    check_eq("t5_issue", 32'(mem_req), 32'd1);
    mem_rvalid = 1'b1;
    mem_rdata  = 16'hDEAD;
    step();
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    check_eq("t5_stray_rvalid", 32'(rvalid), 32'd0);
    check_eq("t5_stray_rdata", 32'(rdata), 32'd0);
    check_eq("t5_still_issue", 32'(mem_req), 32'd1);
    serve(1, 1, 1'b1);

    check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
